ripple_count_capture: RTL and testbench
=======================================

RIPPLE_COUNT_CAPTURE -- requirements
Module: ripple_count_capture

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops per cnt_in bit (legal range 2..4).
REQ-002 Parameter EXT_W, default 16, width of the extended count and snapshot (legal range 8..32).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 cnt_in  input  4  free-running 4-bit up-count from an upstream ripple counter; asynchronous to clk.
REQ-006 clr  input  1  synchronous clear of the extended count and sticky flags.
REQ-007 snap_req  input  1  single-cycle request to capture the extended count.
REQ-008 count  output  EXT_W  live extended count.
REQ-009 snap_data  output  EXT_W  captured count; valid while snap_valid is high.
REQ-010 snap_valid  input/output handshake: snap_valid output 1, snap_ready input 1; a transfer occurs when both are high at a rising clk edge.
REQ-011 overflow  output  1  sticky: the extended count has wrapped past 2^EXT_W-1.
REQ-012 missed  output  1  sticky: snap_req arrived while a snapshot was pending.

Function
REQ-013 Each cnt_in bit shall pass through SYNC_STAGES flops; the result is sync_val.
REQ-014 A stability filter register prev_val shall load sync_val every cycle; a sample is accepted only when sync_val == prev_val.
REQ-015 On acceptance, delta = (sync_val - last_val) mod 16 (4-bit unsigned wrap); count += delta (zero-extended); last_val <= sync_val.
REQ-016 A stable cnt_in change shall appear in count exactly SYNC_STAGES+2 clk cycles after the first edge that samples it.
REQ-017 Wrap of cnt_in 15->0 shall add 1, not subtract 15; any backward jump is treated as a forward wrap (delta mod 16).
REQ-018 count wraps modulo 2^EXT_W; the wrapping add sets overflow, which stays high until clr or reset.
REQ-019 Snapshot FSM states: IDLE, HOLD. In IDLE with snap_req=1, go to HOLD; snap_data <= count value after this cycle's update; snap_valid=1 from the next cycle.
REQ-020 In HOLD, snap_data and snap_valid shall be stable; on snap_valid && snap_ready, return to IDLE with snap_valid=0 in the following cycle.
REQ-021 snap_req in HOLD shall be dropped and set missed; snap_req on the same cycle as the HOLD-exit transfer is also dropped.
REQ-022 clr shall zero count, overflow, missed; last_val <= current sync_val (no delta accumulated that cycle); clr shall not abort a pending snapshot.
REQ-023 clr and acceptance in the same cycle: clr wins.
REQ-024 Correctness requires fewer than 16 upstream increments per SYNC_STAGES+2 clk cycles; faster input is out of contract.

Reset
REQ-025 While reset is high: synchronizers, prev_val, last_val = 0; count = 0; snap_data = 0; snap_valid = 0; overflow = 0; missed = 0; FSM = IDLE.
REQ-026 Reset asserted mid-snapshot shall abandon it; after deassertion, the first accepted sample accumulates its value relative to 0.
REQ-027 The upstream counter shares the same reset, so both sides leave reset at 0.

Structure
REQ-028 A shared package shall hold the FSM state enum (IDLE, HOLD), the CNT_IN_W=4 constant, and the default SYNC_STAGES/EXT_W values.
REQ-029 The per-bit synchronizer shall be one sub-module, sync_chain (parameter STAGES, 1-bit in/out), instantiated 4 times.

Verification
REQ-030 Reset, then cnt_in steps 0->1->...->15->0->3, each held for 8 cycles -> count = 19, overflow = 0.
REQ-031 cnt_in held 5, then snap_req pulse with snap_ready=0 for 10 cycles, then 1 -> snap_valid high from the cycle after the request until the transfer; snap_data = 5, stable throughout.
REQ-032 EXT_W=8, advance cnt_in through 17 full wraps -> count = 272 mod 256 = 16, overflow = 1; clr -> count = 0, overflow = 0.
REQ-033 cnt_in glitches 4->7->4 within 1 clk cycle -> count unchanged at 4 (filter rejects).
REQ-034 Two snap_req pulses 3 cycles apart, snap_ready=0 -> one snapshot held; missed = 1.
REQ-035 Reset asserted while in HOLD with count = 9 -> snap_valid = 0 and count = 0 immediately (asynchronous), FSM returns to IDLE.

Source files
------------

// File: rtl/ripple_count_capture_pkg.sv
// Shared types and constants for the ripple counter capture block.
package ripple_count_capture_pkg;

    localparam int CNT_IN_W        = 4;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int EXT_W_DEF       = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } snap_state_e;

    // Forward distance between two samples of the upstream counter; a
    // backward-looking pair is read as a forward wrap.
    function automatic logic [CNT_IN_W-1:0] wrap_delta(
        input logic [CNT_IN_W-1:0] now_val,
        input logic [CNT_IN_W-1:0] old_val
    );
        return now_val - old_val;
    endfunction

endpackage

// File: rtl/ripple_count_capture_sync_chain.sv
// Single-bit flop chain that brings one asynchronous counter bit into clk.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_r;

    // Shift the asynchronous bit through STAGES flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_r <= {STAGES{1'b0}};
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
        end
    end

    assign q = chain_r[STAGES-1];

endmodule

// File: rtl/ripple_count_capture.sv
// Extends a free-running 4-bit ripple count into an EXT_W-bit count and
// offers snapshots of it over a valid/ready handshake.
module ripple_count_capture
    import ripple_count_capture_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int EXT_W       = EXT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          cnt_in,
    input  logic                clr,
    input  logic                snap_req,
    input  logic                snap_ready,
    output logic [EXT_W-1:0]    count,
    output logic [EXT_W-1:0]    snap_data,
    output logic                snap_valid,
    output logic                overflow,
    output logic                missed
);

    logic [CNT_IN_W-1:0] sync_val_s;
    logic [CNT_IN_W-1:0] prev_val_r;
    logic [CNT_IN_W-1:0] last_val_r;
    logic [CNT_IN_W-1:0] last_next_s;
    logic [CNT_IN_W-1:0] delta_s;
    logic                accept_s;
    logic [EXT_W:0]      sum_s;
    logic [EXT_W-1:0]    count_r;
    logic [EXT_W-1:0]    count_next_s;
    logic [EXT_W-1:0]    snap_data_r;
    logic                overflow_r;
    logic                overflow_next_s;
    logic                missed_r;
    logic                missed_next_s;
    logic                snap_valid_r;
    logic                load_snap_s;
    snap_state_e         state_r;
    snap_state_e         state_next_s;

    for (genvar i = 0; i < CNT_IN_W; i++) begin : g_sync
        sync_chain #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (cnt_in[i]),
            .q     (sync_val_s[i])
        );
    end

    // Accept a synchronized sample only when it matched last cycle's, then accumulate its forward delta
    always_comb begin
        accept_s        = (sync_val_s == prev_val_r);
        delta_s         = wrap_delta(sync_val_s, last_val_r);
        sum_s           = {1'b0, count_r} + {{(EXT_W - CNT_IN_W + 1){1'b0}}, delta_s};
        count_next_s    = count_r;
        overflow_next_s = overflow_r;
        last_next_s     = last_val_r;
        if (clr) begin
            // Re-anchor on the current sample so nothing accumulates this cycle
            count_next_s    = {EXT_W{1'b0}};
            overflow_next_s = 1'b0;
            last_next_s     = sync_val_s;
        end else if (accept_s) begin
            count_next_s    = sum_s[EXT_W-1:0];
            overflow_next_s = overflow_r | sum_s[EXT_W];
            last_next_s     = sync_val_s;
        end else begin
            count_next_s    = count_r;
            overflow_next_s = overflow_r;
            last_next_s     = last_val_r;
        end
    end

    // Snapshot FSM next state, capture strobe and missed-request flag
    always_comb begin
        state_next_s  = state_r;
        load_snap_s   = 1'b0;
        missed_next_s = missed_r;
        case (state_r)
            IDLE: begin
                if (snap_req) begin
                    state_next_s = HOLD;
                    load_snap_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            HOLD: begin
                // Requests while a snapshot is pending, including the exit cycle, are dropped
                if (snap_req) begin
                    missed_next_s = 1'b1;
                end else begin
                    missed_next_s = missed_r;
                end
                if (snap_valid_r && snap_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        if (clr) begin
            missed_next_s = 1'b0;
        end else begin
            missed_next_s = missed_next_s;
        end
    end

    // Register the filter, accumulator, snapshot and flag state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_val_r   <= {CNT_IN_W{1'b0}};
            last_val_r   <= {CNT_IN_W{1'b0}};
            count_r      <= {EXT_W{1'b0}};
            overflow_r   <= 1'b0;
            missed_r     <= 1'b0;
            snap_data_r  <= {EXT_W{1'b0}};
            snap_valid_r <= 1'b0;
            state_r      <= IDLE;
        end else begin
            prev_val_r   <= sync_val_s;
            last_val_r   <= last_next_s;
            count_r      <= count_next_s;
            overflow_r   <= overflow_next_s;
            missed_r     <= missed_next_s;
            snap_valid_r <= (state_next_s == HOLD);
            state_r      <= state_next_s;
            if (load_snap_s) begin
                snap_data_r <= count_next_s;
            end else begin
                snap_data_r <= snap_data_r;
            end
        end
    end

    assign count      = count_r;
    assign snap_data  = snap_data_r;
    assign snap_valid = snap_valid_r;
    assign overflow   = overflow_r;
    assign missed     = missed_r;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed bench for ripple_count_capture with a snapshot scoreboard.
module tb_ripple_count_capture;

    logic        clk;
    logic        reset;
    logic [3:0]  cnt_in;
    logic        clr;
    logic        snap_req;
    logic        snap_ready;
    logic [15:0] count;
    logic [15:0] snap_data;
    logic        snap_valid;
    logic        overflow;
    logic        missed;

    logic [3:0]  cnt_in2;
    logic        clr2;
    logic        snap_req2;
    logic        snap_ready2;
    logic [7:0]  count2;
    logic [7:0]  snap_data2;
    logic        snap_valid2;
    logic        overflow2;
    logic        missed2;

    int          n_vec;
    int          n_err;
    logic [15:0] exp_q[$];

    ripple_count_capture #(.SYNC_STAGES(2), .EXT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .cnt_in     (cnt_in),
        .clr        (clr),
        .snap_req   (snap_req),
        .snap_ready (snap_ready),
        .count      (count),
        .snap_data  (snap_data),
        .snap_valid (snap_valid),
        .overflow   (overflow),
        .missed     (missed)
    );

    ripple_count_capture #(.SYNC_STAGES(3), .EXT_W(8)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .cnt_in     (cnt_in2),
        .clr        (clr2),
        .snap_req   (snap_req2),
        .snap_ready (snap_ready2),
        .count      (count2),
        .snap_data  (snap_data2),
        .snap_valid (snap_valid2),
        .overflow   (overflow2),
        .missed     (missed2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic set_cnt(input logic [3:0] v, input int hold);
        @(posedge clk); #1;
        cnt_in = v;
        cycles(hold);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cnt_in = 4'd0;
        cnt_in2 = 4'd0;
        snap_req = 1'b0;
        snap_ready = 1'b0;
        clr = 1'b0;
        exp_q.delete();
        cycles(2);
        reset = 1'b0;
    endtask

    task automatic pulse_req();
        @(posedge clk); #1;
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
    endtask

    task automatic transfer();
        @(posedge clk); #1;
        snap_ready = 1'b1;
        @(posedge clk); #1;
        snap_ready = 1'b0;
    endtask

    // Scoreboard monitor: while a snapshot is offered it must match the queued value; pop on transfer
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && snap_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL snap_unexpected: got valid data %0d, expected no snapshot", snap_data);
                end else begin
                    chk("snap_data", 32'(snap_data), 32'(exp_q[0]));
                    if (snap_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        cnt_in = 4'd0;
        clr = 1'b0;
        snap_req = 1'b0;
        snap_ready = 1'b0;
        cnt_in2 = 4'd0;
        clr2 = 1'b0;
        snap_req2 = 1'b0;
        snap_ready2 = 1'b0;

        // Reset state
        cycles(3);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_snap_data", 32'(snap_data), 32'd0);
        chk("rst_snap_valid", 32'(snap_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_missed", 32'(missed), 32'd0);
        reset = 1'b0;
        cycles(4);

        // Latency: a change sampled at edge 1 shows at edge SYNC_STAGES+2 = 4
        cnt_in = 4'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("latency_before", 32'(count), 32'd0);
        @(negedge clk);
        chk("latency_at", 32'(count), 32'd1);
        cycles(4);

        // Steps 2..15, wrap to 0, then jump to 3: 15 + 1 + 3 = 19
        for (int v = 2; v < 16; v++) set_cnt(4'(v), 8);
        chk("step_15", 32'(count), 32'd15);
        set_cnt(4'd0, 8);
        chk("wrap_15_0", 32'(count), 32'd16);
        set_cnt(4'd3, 8);
        chk("step_count", 32'(count), 32'd19);
        chk("step_overflow", 32'(overflow), 32'd0);

        // Snapshot held 10 cycles with ready low, then transferred
        do_reset();
        set_cnt(4'd5, 8);
        chk("snap_count", 32'(count), 32'd5);
        exp_q.push_back(16'd5);
        pulse_req();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("snap_valid_hold", 32'(snap_valid), 32'd1);
        end
        transfer();
        @(negedge clk);
        chk("snap_valid_after", 32'(snap_valid), 32'd0);

        // Glitch 4->7->4 spanning one sampling edge is filtered
        do_reset();
        set_cnt(4'd4, 8);
        chk("glitch_pre", 32'(count), 32'd4);
        @(negedge clk);
        cnt_in = 4'd7;
        @(negedge clk);
        cnt_in = 4'd4;
        cycles(8);
        chk("glitch_count", 32'(count), 32'd4);
        chk("glitch_overflow", 32'(overflow), 32'd0);

        // Two requests 3 cycles apart: one snapshot, missed set; clr keeps the snapshot pending
        exp_q.push_back(16'd4);
        @(posedge clk); #1;
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
        cycles(2);
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
        @(negedge clk);
        chk("missed_set", 32'(missed), 32'd1);
        chk("missed_valid", 32'(snap_valid), 32'd1);
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        chk("clr_missed", 32'(missed), 32'd0);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_keeps_valid", 32'(snap_valid), 32'd1);
        transfer();
        @(negedge clk);
        chk("missed_valid_after", 32'(snap_valid), 32'd0);
        set_cnt(4'd6, 8);
        chk("clr_reanchor", 32'(count), 32'd2);

        // Reset in HOLD with count 9 abandons the snapshot immediately
        do_reset();
        set_cnt(4'd9, 8);
        chk("hold_count", 32'(count), 32'd9);
        exp_q.push_back(16'd9);
        pulse_req();
        cycles(2);
        @(negedge clk);
        reset = 1'b1;
        cnt_in = 4'd0;
        exp_q.delete();
        #1;
        chk("async_rst_valid", 32'(snap_valid), 32'd0);
        chk("async_rst_count", 32'(count), 32'd0);
        cycles(2);
        reset = 1'b0;
        cycles(2);
        chk("post_rst_valid", 32'(snap_valid), 32'd0);
        set_cnt(4'd2, 8);
        chk("post_rst_count", 32'(count), 32'd2);

        // EXT_W=8: 17 full wraps -> 272 mod 256 = 16 with overflow; clr clears both
        for (int i = 0; i < 240; i++) begin
            @(posedge clk); #1;
            cnt_in2 = cnt_in2 + 4'd1;
            cycles(3);
        end
        cycles(10);
        chk("w8_count_240", 32'(count2), 32'd240);
        chk("w8_overflow_240", 32'(overflow2), 32'd0);
        for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            cnt_in2 = cnt_in2 + 4'd1;
            cycles(3);
        end
        cycles(10);
        chk("w8_count_272", 32'(count2), 32'd16);
        chk("w8_overflow", 32'(overflow2), 32'd1);
        chk("w8_snap_valid", 32'(snap_valid2), 32'd0);
        @(posedge clk); #1;
        clr2 = 1'b1;
        @(posedge clk); #1;
        clr2 = 1'b0;
        chk("w8_clr_count", 32'(count2), 32'd0);
        chk("w8_clr_overflow", 32'(overflow2), 32'd0);

        // Every queued snapshot must have been delivered
        cycles(2);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
